// File: rtl/uart_cmd_decoder.sv
// UART command decoder: opcode plus MSB-first operands become one command, valid 1 cycle after the last byte and held until i_Cmd_Ready.
// Bytes arriving while a command is held are dropped as overrun; define UART_CMD_TIMEOUT_EN to abort stalled operands.
module uart_cmd_decoder #(
  parameter int CLKS_PER_BIT = -1,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        i_Clock,
  input  logic        i_Rst_N,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Cmd_Valid,
  input  logic        i_Cmd_Ready,
  output logic [7:0]  o_Cmd_Op,
  output logic [31:0] o_Cmd_Addr,
  output logic [31:0] o_Cmd_Data,
  output logic        o_Err,
  output logic [1:0]  o_Err_Code
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_DATA  = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;

  localparam logic [1:0] ERR_BAD_OP  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [7:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_err;
  logic [1:0]  r_err_code;
  logic [1:0]  r_rst_sync;

  logic w_run;
  logic w_op_valid;
  logic w_timeout;

  // Reset assertion is immediate; release only takes effect after two clock edges.
  always_ff @(posedge i_Clock or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_run      = r_rst_sync[1];
  assign w_op_valid = (i_Rx_Byte >= 8'h01) && (i_Rx_Byte <= 8'h05);

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_collecting;

  assign w_collecting = (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_timeout    = w_collecting && !i_Rx_DV && (r_to_cnt == TO_W'(TO_LIMIT - 1));

  always_ff @(posedge i_Clock or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      r_to_cnt <= '0;
    end else if (w_run) begin
      if (!w_collecting || i_Rx_DV || w_timeout) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_Clock or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      r_state    <= S_IDLE;
      r_cnt      <= 2'd0;
      r_op       <= 8'h00;
      r_addr     <= 32'h0;
      r_data     <= 32'h0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end else if (w_run) begin
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
      case (r_state)
        S_IDLE: begin
          if (i_Rx_DV) begin
            if (w_op_valid) begin
              r_op   <= i_Rx_Byte;
              r_addr <= 32'h0;
              r_data <= 32'h0;
              r_cnt  <= 2'd0;
              if ((i_Rx_Byte == OP_READ) || (i_Rx_Byte == OP_WRITE)) begin
                r_state <= S_ADDR;
              end else begin
                r_state <= S_ISSUE;
              end
            end else begin
              r_err      <= 1'b1;
              r_err_code <= ERR_BAD_OP;
            end
          end
        end

        S_ADDR: begin
          if (w_timeout) begin
            r_state    <= S_IDLE;
            r_cnt      <= 2'd0;
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
          end else if (i_Rx_DV) begin
            r_addr <= {r_addr[23:0], i_Rx_Byte};
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= (r_op == OP_WRITE) ? S_DATA : S_ISSUE;
            end
          end
        end

        S_DATA: begin
          if (w_timeout) begin
            r_state    <= S_IDLE;
            r_cnt      <= 2'd0;
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
          end else if (i_Rx_DV) begin
            r_data <= {r_data[23:0], i_Rx_Byte};
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          // Command fields stay frozen here; any byte is lost, even on the accept cycle.
          if (i_Rx_DV) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_OVERRUN;
          end
          if (i_Cmd_Ready) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 2'd0;
        end
      endcase
    end
  end

  assign o_Cmd_Valid = (r_state == S_ISSUE);
  assign o_Cmd_Op    = r_op;
  assign o_Cmd_Addr  = r_addr;
  assign o_Cmd_Data  = r_data;
  assign o_Err       = r_err;
  assign o_Err_Code  = r_err_code;

endmodule
